// File: rtl/lisnoc16_noc_to_usb_pkg.sv
// Shared sizing and flit-format definitions for the NoC16-to-USB return path.
// LD sets the packet buffer depth: MAXLEN = 2**LD - 1 flits.
package lisnoc16_noc_to_usb_pkg;

  localparam int LD_MAX_NOC16_PACKET_LENGTH = 4;
  localparam int LD                         = LD_MAX_NOC16_PACKET_LENGTH;
  localparam int MAXLEN                     = 2**LD - 1;
  localparam logic [LD-1:0] MAXLEN_W        = LD'(MAXLEN);

  localparam int FLIT16_TYPE_MSB    = 17;
  localparam int FLIT16_TYPE_LSB    = 16;
  localparam int FLIT16_CONTENT_MSB = 15;
  localparam int FLIT16_CONTENT_LSB = 0;

  typedef enum logic [1:0] {
    FLIT16_TYPE_PAYLOAD = 2'b00,
    FLIT16_TYPE_HEADER  = 2'b01,
    FLIT16_TYPE_LAST    = 2'b10,
    FLIT16_TYPE_SINGLE  = 2'b11
  } flit16_type_e;

endpackage

// File: rtl/lisnoc16_usb_pkt_buf.sv
// Single-packet store: MAXLEN x 16 register array with one synchronous write
// port and one asynchronous read port.
module lisnoc16_usb_pkt_buf
  import lisnoc16_noc_to_usb_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [LD-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [LD-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem_q [MAXLEN];

  // NOTE: the array has no reset; the controller only ever reads words it wrote earlier in the same packet.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lisnoc16_noc_to_usb.sv
// Store-and-forward NoC16 flit -> USB word converter: buffers one packet, then
// emits a length header and the payload. Optional err_count: LISNOC16_NOC_TO_USB_ERRCNT_EN.
module lisnoc16_noc_to_usb
  import lisnoc16_noc_to_usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] in_noc_data,
  input  logic        in_noc_valid,
  output logic        in_noc_ready,
  output logic [15:0] out_usb_data,
  output logic        out_usb_valid,
  input  logic        out_usb_ready
`ifdef LISNOC16_NOC_TO_USB_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {
    ST_RECV      = 2'd0,
    ST_SEND_HDR  = 2'd1,
    ST_SEND_DATA = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [LD-1:0] wr_cnt_q, wr_cnt_d;
  logic [LD-1:0] rd_cnt_q, rd_cnt_d;
  logic [LD-1:0] len_q, len_d;

  flit16_type_e  flit_type;
  logic [15:0]   flit_content;
  logic          buf_we;
  logic [LD-1:0] buf_waddr;
  logic [15:0]   buf_rdata;

  assign flit_type    = flit16_type_e'(in_noc_data[FLIT16_TYPE_MSB:FLIT16_TYPE_LSB]);
  assign flit_content = in_noc_data[FLIT16_CONTENT_MSB:FLIT16_CONTENT_LSB];

  lisnoc16_usb_pkt_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (flit_content),
    .raddr (rd_cnt_q),
    .rdata (buf_rdata)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    len_d         = len_q;
    buf_we        = 1'b0;
    buf_waddr     = '0;
    in_noc_ready  = 1'b0;
    out_usb_valid = 1'b0;
    out_usb_data  = '0;

    unique case (state_q)
      ST_RECV: begin
        in_noc_ready = 1'b1;
        if (in_noc_valid) begin
          // Idle, or a HEADER/SINGLE mid-packet: the partial packet is abandoned.
          if (wr_cnt_q == '0 || flit_type == FLIT16_TYPE_HEADER ||
              flit_type == FLIT16_TYPE_SINGLE) begin
            wr_cnt_d = '0;
            if (flit_type == FLIT16_TYPE_HEADER) begin
              buf_we   = 1'b1;
              wr_cnt_d = LD'(1);
            end else if (flit_type == FLIT16_TYPE_SINGLE) begin
              buf_we  = 1'b1;
              len_d   = LD'(1);
              state_d = ST_SEND_HDR;
            end
          end else if (wr_cnt_q == MAXLEN_W) begin
            // Buffer full: drop everything up to LAST, then send what fits.
            if (flit_type == FLIT16_TYPE_LAST) begin
              len_d    = MAXLEN_W;
              wr_cnt_d = '0;
              state_d  = ST_SEND_HDR;
            end
          end else begin
            buf_we    = 1'b1;
            buf_waddr = wr_cnt_q;
            if (flit_type == FLIT16_TYPE_PAYLOAD) begin
              wr_cnt_d = wr_cnt_q + LD'(1);
            end else begin
              len_d    = wr_cnt_q + LD'(1);
              wr_cnt_d = '0;
              state_d  = ST_SEND_HDR;
            end
          end
        end
      end

      ST_SEND_HDR: begin
        out_usb_valid = 1'b1;
        out_usb_data  = {{(16-LD){1'b0}}, len_q};
        if (out_usb_ready) begin
          rd_cnt_d = '0;
          state_d  = ST_SEND_DATA;
        end
      end

      ST_SEND_DATA: begin
        out_usb_valid = 1'b1;
        out_usb_data  = buf_rdata;
        if (out_usb_ready) begin
          rd_cnt_d = rd_cnt_q + LD'(1);
          if (rd_cnt_q == len_q - LD'(1)) begin
            wr_cnt_d = '0;
            state_d  = ST_RECV;
          end
        end
      end

      default: state_d = ST_RECV;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RECV;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      len_q    <= len_d;
    end
  end

`ifdef LISNOC16_NOC_TO_USB_ERRCNT_EN
  logic [7:0] err_q, err_d;
  logic       err_ev;

  // One event per dropped/truncated flit or per abandoned partial packet.
  always_comb begin
    err_ev = 1'b0;
    if (state_q == ST_RECV && in_noc_valid) begin
      case (flit_type)
        FLIT16_TYPE_PAYLOAD,
        FLIT16_TYPE_LAST:   err_ev = (wr_cnt_q == '0) || (wr_cnt_q == MAXLEN_W);
        default:            err_ev = (wr_cnt_q != '0);
      endcase
    end
    err_d = (err_ev && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= '0;
    else      err_q <= err_d;
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_lisnoc16_noc_to_usb.sv
// Self-checking bench: directed scenarios plus randomized packet streams scored
// against a queue-based packet model.
module tb_lisnoc16_noc_to_usb;
  import lisnoc16_noc_to_usb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] in_noc_data;
  logic        in_noc_valid;
  logic        in_noc_ready;
  logic [15:0] out_usb_data;
  logic        out_usb_valid;
  logic        out_usb_ready = 1'b1;
`ifdef LISNOC16_NOC_TO_USB_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  lisnoc16_noc_to_usb dut (
    .clk           (clk),
    .rst           (rst),
    .in_noc_data   (in_noc_data),
    .in_noc_valid  (in_noc_valid),
    .in_noc_ready  (in_noc_ready),
    .out_usb_data  (out_usb_data),
    .out_usb_valid (out_usb_valid),
    .out_usb_ready (out_usb_ready)
`ifdef LISNOC16_NOC_TO_USB_ERRCNT_EN
    ,
    .err_count     (err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: packets as queues of words, errors counted per rule.
  logic [15:0] exp_q[$];
  logic [15:0] m_cur[$];
  bit          m_in_pkt = 0;
  int          m_err    = 0;

  function automatic void m_bump();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void m_emit();
    exp_q.push_back(16'(m_cur.size()));
    foreach (m_cur[i]) exp_q.push_back(m_cur[i]);
    m_cur.delete();
    m_in_pkt = 0;
  endfunction

  function automatic void model_feed(input logic [1:0] t, input logic [15:0] c);
    case (flit16_type_e'(t))
      FLIT16_TYPE_HEADER: begin
        if (m_in_pkt) m_bump();
        m_cur.delete();
        m_cur.push_back(c);
        m_in_pkt = 1;
      end
      FLIT16_TYPE_SINGLE: begin
        if (m_in_pkt) m_bump();
        m_cur.delete();
        m_cur.push_back(c);
        m_emit();
      end
      FLIT16_TYPE_PAYLOAD: begin
        if (!m_in_pkt || m_cur.size() == MAXLEN) m_bump();
        else m_cur.push_back(c);
      end
      default: begin
        if (!m_in_pkt) m_bump();
        else begin
          if (m_cur.size() == MAXLEN) m_bump();
          else m_cur.push_back(c);
          m_emit();
        end
      end
    endcase
  endfunction

  // out_usb_ready pattern: 0 = always ready, 1 = toggling, 2 = random.
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_usb_ready = 1'b1;
      1:       out_usb_ready = ~out_usb_ready;
      default: out_usb_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor, sampled on the falling edge.
  int          words_seen = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data  = '0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 0;
    end else begin
      if (!out_usb_valid) check("idle_data_zero", 32'(out_usb_data), 32'h0);
      check("no_overlap", 32'(in_noc_ready & out_usb_valid), 32'h0);
      if (prev_stall) begin
        check("hold_valid", 32'(out_usb_valid), 32'h1);
        check("hold_data", 32'(out_usb_data), 32'(prev_data));
      end
      if (out_usb_valid && out_usb_ready) begin
        words_seen++;
        if (exp_q.size() == 0) check("unexpected_word", 32'(exp_q.size()), 32'h1);
        else check("usb_word", 32'(out_usb_data), 32'(exp_q.pop_front()));
      end
      prev_stall = out_usb_valid && !out_usb_ready;
      prev_data  = out_usb_data;
    end
  end

  // Entered and left at posedge+1.
  task automatic send_flit(input logic [1:0] t, input logic [15:0] c);
    int n = 0;
    in_noc_data  = {t, c};
    in_noc_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_noc_ready) break;
      n++;
      if (n > 500) begin
        check("flit_accept_timeout", 32'(n), 32'h0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_noc_valid = 1'b0;
    if (n <= 500) model_feed(t, c);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_noc_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_err(input string tag);
`ifdef LISNOC16_NOC_TO_USB_ERRCNT_EN
    check(tag, 32'(err_count), 32'(m_err));
`endif
  endtask

  initial begin
    int cnt;
    int base;
    rst          = 1'b0;
    in_noc_valid = 1'b0;
    in_noc_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_noc_ready), 32'h1);
    check("rst_out_valid", 32'(out_usb_valid), 32'h0);
    check("rst_out_data", 32'(out_usb_data), 32'h0);
    check_err("rst_err_count");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // SINGLE: two output words, input stalled exactly two cycles.
    send_flit(FLIT16_TYPE_SINGLE, 16'h1234);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_noc_ready) break;
      cnt++;
    end
    check("single_ready_low_cycles", 32'(cnt), 32'd2);
    drain();

    // Three-flit packet; header one cycle after LAST is accepted.
    send_flit(FLIT16_TYPE_HEADER, 16'hA000);
    send_flit(FLIT16_TYPE_PAYLOAD, 16'hA001);
    send_flit(FLIT16_TYPE_LAST, 16'hA002);
    @(negedge clk);
    check("hdr_latency_valid", 32'(out_usb_valid), 32'h1);
    check("hdr_latency_data", 32'(out_usb_data), 32'h3);
    drain();

    // Same packet with a toggling sink.
    ready_mode = 1;
    send_flit(FLIT16_TYPE_HEADER, 16'hA000);
    send_flit(FLIT16_TYPE_PAYLOAD, 16'hA001);
    send_flit(FLIT16_TYPE_LAST, 16'hA002);
    drain();
    ready_mode = 0;

    // Stray PAYLOAD while idle is dropped.
    send_flit(FLIT16_TYPE_PAYLOAD, 16'hDEAD);
    send_flit(FLIT16_TYPE_SINGLE, 16'h0005);
    drain();
    check_err("err_after_stray");

    // Overflow: HEADER, MAXLEN payloads, LAST.
    send_flit(FLIT16_TYPE_HEADER, 16'h7000);
    for (int i = 1; i <= MAXLEN; i++) send_flit(FLIT16_TYPE_PAYLOAD, 16'(16'h7000 + i));
    send_flit(FLIT16_TYPE_LAST, 16'h7FFF);
    drain();
    check_err("err_after_overflow");

    // Reset after the header and one payload word have been taken.
    send_flit(FLIT16_TYPE_HEADER, 16'h0B00);
    send_flit(FLIT16_TYPE_PAYLOAD, 16'h0B01);
    send_flit(FLIT16_TYPE_LAST, 16'h0B02);
    base = words_seen;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_words_taken", 32'(words_seen - base), 32'd2);
    check("midrst_out_valid", 32'(out_usb_valid), 32'h0);
    check("midrst_out_data", 32'(out_usb_data), 32'h0);
    check("midrst_in_ready", 32'(in_noc_ready), 32'h1);
    exp_q.delete();
    m_cur.delete();
    m_in_pkt = 0;
    m_err    = 0;
    check_err("midrst_err_count");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_flit(FLIT16_TYPE_SINGLE, 16'h00FF);
    drain();

    // Randomized packet streams with occasional stray flits and sink stalls.
    for (int p = 0; p < 40; p++) begin
      int len;
      ready_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0)
        send_flit(2'($urandom_range(0, 3)), 16'($urandom));
      len = $urandom_range(1, MAXLEN + 2);
      if (len == 1) begin
        send_flit(FLIT16_TYPE_SINGLE, 16'($urandom));
      end else begin
        send_flit(FLIT16_TYPE_HEADER, 16'($urandom));
        for (int i = 0; i < len - 2; i++) send_flit(FLIT16_TYPE_PAYLOAD, 16'($urandom));
        send_flit(FLIT16_TYPE_LAST, 16'($urandom));
      end
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    check_err("err_after_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
